// File: rtl/game_if.sv
// Signal bundle between the keypad/collision sources and the game controller.
interface game_if;
    logic       key_ready;
    logic       frame_tick;
    logic       pipe_passed;
    logic       is_dead;
    logic [1:0] state;
    logic       flap;
    logic       game_rst;
    logic [7:0] score;
    logic [7:0] best;

    modport master (
        output key_ready, frame_tick, pipe_passed, is_dead,
        input  state, flap, game_rst, score, best
    );

    modport slave (
        input  key_ready, frame_tick, pipe_passed, is_dead,
        output state, flap, game_rst, score, best
    );
endinterface

// File: rtl/game_fsm.sv
// Registered WAIT/FLY/DEAD game controller with BCD score/best counters
// and a frame-timed restart hold-off after death.
module game_fsm #(
    parameter int         DEAD_HOLD = 60,
    parameter logic [7:0] SCORE_MAX = 8'h99
) (
    input logic   clk,
    input logic   rst,
    game_if.slave bus
);
    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_FLY  = 2'd1;
    localparam logic [1:0] S_DEAD = 2'd2;
    localparam logic [7:0] HOLD_INIT = 8'(DEAD_HOLD);

    logic [1:0] state_q;
    logic       flap_q;
    logic       game_rst_q;
    logic [7:0] score_q;
    logic [7:0] best_q;
    logic [7:0] hold_q;
    logic       key_q;
    logic       press;

    // key_q resets high so a key held through reset is not seen as a press
    assign press = bus.key_ready & ~key_q;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v >= SCORE_MAX)
            return SCORE_MAX;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_WAIT;
            flap_q     <= 1'b0;
            game_rst_q <= 1'b0;
            score_q    <= 8'h00;
            best_q     <= 8'h00;
            hold_q     <= 8'h00;
            key_q      <= 1'b1;
        end else begin
            key_q      <= bus.key_ready;
            flap_q     <= 1'b0;
            game_rst_q <= 1'b0;
            case (state_q)
                S_WAIT: begin
                    score_q <= 8'h00;
                    if (press) begin
                        state_q <= S_FLY;
                        flap_q  <= 1'b1;
                    end
                end
                S_FLY: begin
                    // death takes priority over a same-cycle flap or score
                    if (bus.is_dead) begin
                        state_q <= S_DEAD;
                        hold_q  <= HOLD_INIT;
                        if (score_q > best_q)
                            best_q <= score_q;
                    end else begin
                        if (press)
                            flap_q <= 1'b1;
                        if (bus.pipe_passed)
                            score_q <= bcd_inc(score_q);
                    end
                end
                S_DEAD: begin
                    if (bus.frame_tick && hold_q != 8'h00)
                        hold_q <= hold_q - 8'h01;
                    if (press && hold_q == 8'h00) begin
                        state_q    <= S_WAIT;
                        game_rst_q <= 1'b1;
                        score_q    <= 8'h00;
                    end
                end
                default: state_q <= S_WAIT;
            endcase
        end
    end

    assign bus.state    = state_q;
    assign bus.flap     = flap_q;
    assign bus.game_rst = game_rst_q;
    assign bus.score    = score_q;
    assign bus.best     = best_q;
endmodule

// File: tb/tb_game_fsm.sv
// Bench for game_fsm: vector table for the first games, hand sequences for
// scoring runs, restart hold-off and asynchronous reset.
module tb_game_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_if bus ();
    game_fsm #(.DEAD_HOLD(3), .SCORE_MAX(8'h99)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0] in;  // {key, tick, pipe, dead}
        logic [1:0] st;
        logic       fl;
        logic       gr;
        logic [7:0] sc;
        logic [7:0] bs;
    } vec_t;

    vec_t exp_q[$];
    vec_t vt[25];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [3:0] in, input logic [1:0] st,
                                input logic fl, input logic gr,
                                input logic [7:0] sc, input logic [7:0] bs);
        vec_t r;
        r.in = in; r.st = st; r.fl = fl; r.gr = gr; r.sc = sc; r.bs = bs;
        return r;
    endfunction

    // decimal count -> saturated two-digit BCD
    function automatic logic [7:0] bcd(input int n);
        int m;
        m = (n > 99) ? 99 : n;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic check_now(input vec_t e, input string nm);
        n_vec++;
        if (bus.state !== e.st || bus.flap !== e.fl || bus.game_rst !== e.gr ||
            bus.score !== e.sc || bus.best !== e.bs) begin
            n_err++;
            $display("FAIL %s: got st=%0d flap=%0b grst=%0b score=%h best=%h, want st=%0d flap=%0b grst=%0b score=%h best=%h",
                     nm, bus.state, bus.flap, bus.game_rst, bus.score, bus.best,
                     e.st, e.fl, e.gr, e.sc, e.bs);
        end
    endtask

    // drive one cycle of inputs, queue the expected post-edge outputs, compare
    task automatic step(input vec_t v, input string nm);
        vec_t e;
        @(negedge clk);
        {bus.key_ready, bus.frame_tick, bus.pipe_passed, bus.is_dead} = v.in;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_now(e, nm);
    endtask

    initial begin
        bus.key_ready = 1'b0; bus.frame_tick = 1'b0;
        bus.pipe_passed = 1'b0; bus.is_dead = 1'b0;

        // game A: start, flaps, score 5, die with same-cycle pipe, hold-off
        vt[0]  = mk(4'b0000, 2'd0, 0, 0, 8'h00, 8'h00);
        vt[1]  = mk(4'b1000, 2'd1, 1, 0, 8'h00, 8'h00);
        vt[2]  = mk(4'b1000, 2'd1, 0, 0, 8'h00, 8'h00);
        vt[3]  = mk(4'b0000, 2'd1, 0, 0, 8'h00, 8'h00);
        vt[4]  = mk(4'b1000, 2'd1, 1, 0, 8'h00, 8'h00);
        vt[5]  = mk(4'b0010, 2'd1, 0, 0, 8'h01, 8'h00);
        vt[6]  = mk(4'b0010, 2'd1, 0, 0, 8'h02, 8'h00);
        vt[7]  = mk(4'b0010, 2'd1, 0, 0, 8'h03, 8'h00);
        vt[8]  = mk(4'b0010, 2'd1, 0, 0, 8'h04, 8'h00);
        vt[9]  = mk(4'b0010, 2'd1, 0, 0, 8'h05, 8'h00);
        vt[10] = mk(4'b0011, 2'd2, 0, 0, 8'h05, 8'h05);
        vt[11] = mk(4'b0100, 2'd2, 0, 0, 8'h05, 8'h05);
        vt[12] = mk(4'b0100, 2'd2, 0, 0, 8'h05, 8'h05);
        vt[13] = mk(4'b1000, 2'd2, 0, 0, 8'h05, 8'h05);
        vt[14] = mk(4'b0000, 2'd2, 0, 0, 8'h05, 8'h05);
        vt[15] = mk(4'b0100, 2'd2, 0, 0, 8'h05, 8'h05);
        vt[16] = mk(4'b1000, 2'd0, 0, 1, 8'h00, 8'h05);
        vt[17] = mk(4'b1000, 2'd0, 0, 0, 8'h00, 8'h05);
        vt[18] = mk(4'b0000, 2'd0, 0, 0, 8'h00, 8'h05);
        vt[19] = mk(4'b0011, 2'd0, 0, 0, 8'h00, 8'h05);
        // game B: score 3, die with same-cycle press -> no flap, best kept
        vt[20] = mk(4'b1000, 2'd1, 1, 0, 8'h00, 8'h05);
        vt[21] = mk(4'b0010, 2'd1, 0, 0, 8'h01, 8'h05);
        vt[22] = mk(4'b0010, 2'd1, 0, 0, 8'h02, 8'h05);
        vt[23] = mk(4'b0010, 2'd1, 0, 0, 8'h03, 8'h05);
        vt[24] = mk(4'b1001, 2'd2, 0, 0, 8'h03, 8'h05);

        #1;
        check_now(mk(4'b0000, 2'd0, 0, 0, 8'h00, 8'h00), "reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 25; i++)
            step(vt[i], $sformatf("vec%0d", i));

        // leave DEAD after game B (hold reloaded to 3)
        for (int i = 0; i < 4; i++)
            step(mk(4'b0100, 2'd2, 0, 0, 8'h03, 8'h05), "dead_tick_b");
        step(mk(4'b1000, 2'd0, 0, 1, 8'h00, 8'h05), "restart_b");
        step(mk(4'b0000, 2'd0, 0, 0, 8'h00, 8'h05), "wait_b");

        // game C: score 20 -> new best
        step(mk(4'b1000, 2'd1, 1, 0, 8'h00, 8'h05), "start_c");
        step(mk(4'b0000, 2'd1, 0, 0, 8'h00, 8'h05), "fly_c");
        for (int i = 1; i <= 20; i++)
            step(mk(4'b0010, 2'd1, 0, 0, bcd(i), 8'h05), $sformatf("score_c%0d", i));
        step(mk(4'b0001, 2'd2, 0, 0, 8'h20, 8'h20), "die_c");
        for (int i = 0; i < 3; i++)
            step(mk(4'b0100, 2'd2, 0, 0, 8'h20, 8'h20), "dead_tick_c");
        step(mk(4'b1000, 2'd0, 0, 1, 8'h00, 8'h20), "restart_c");
        step(mk(4'b0000, 2'd0, 0, 0, 8'h00, 8'h20), "wait_c");

        // game D: count through 09->10 carry, 12, and saturate at 99
        step(mk(4'b1000, 2'd1, 1, 0, 8'h00, 8'h20), "start_d");
        step(mk(4'b0000, 2'd1, 0, 0, 8'h00, 8'h20), "fly_d");
        for (int i = 1; i <= 102; i++)
            step(mk(4'b0010, 2'd1, 0, 0, bcd(i), 8'h20), $sformatf("score_d%0d", i));
        step(mk(4'b0001, 2'd2, 0, 0, 8'h99, 8'h99), "die_d");
        for (int i = 0; i < 3; i++)
            step(mk(4'b0100, 2'd2, 0, 0, 8'h99, 8'h99), "dead_tick_d");
        step(mk(4'b1000, 2'd0, 0, 1, 8'h00, 8'h99), "restart_d");
        step(mk(4'b0000, 2'd0, 0, 0, 8'h00, 8'h99), "wait_d");

        // game E: async reset mid-FLY with the key held
        step(mk(4'b1000, 2'd1, 1, 0, 8'h00, 8'h99), "start_e");
        step(mk(4'b1000, 2'd1, 0, 0, 8'h00, 8'h99), "held_e");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_now(mk(4'b1000, 2'd0, 0, 0, 8'h00, 8'h00), "async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(mk(4'b1000, 2'd0, 0, 0, 8'h00, 8'h00), "held_after_rst");
        step(mk(4'b1000, 2'd0, 0, 0, 8'h00, 8'h00), "held_after_rst2");
        step(mk(4'b0000, 2'd0, 0, 0, 8'h00, 8'h00), "release_after_rst");
        step(mk(4'b1000, 2'd1, 1, 0, 8'h00, 8'h00), "press_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
